uart_rx_sipo: RTL and testbench

Serial-in/parallel-out UART receiver: the receive-side counterpart of the team's UART transmitter. It samples the serial line with an oversampled baud clock, detects start bits, shifts in 8 data bits LSB-first plus one parity bit and one stop bit, and presents the byte with error flags on a one-cycle valid strobe. It sits between the pad-side `data_rx` line and the receive FIFO or host logic.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sipo_if.sv | 32 +++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx_sipo.sv | 157 +++++++++++++++
 tb/tb_uart_rx_sipo.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART frame constants, FSM state type and parity helper
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Parity bit a transmitter sends for this byte; odd=1 selects odd parity.
  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sipo_if.sv
// ============================================================================
// uart_rx_sipo_if : serial input and received-byte outputs of the UART receiver
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_sipo_if;
  import uart_pkg::*;

  logic                      data_rx;
  logic [UART_DATA_BITS-1:0] data_out;
  logic                      data_valid;
  logic                      parity_error;
  logic                      framing_error;
  logic                      active_flag;
  logic                      done_flag;

  modport master (
    input  data_rx,
    output data_out, data_valid, parity_error, framing_error,
           active_flag, done_flag
  );

  modport slave (
    output data_rx,
    input  data_out, data_valid, parity_error, framing_error,
           active_flag, done_flag
  );

endinterface

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// uart_rx_sync : 2-FF synchronizer, asynchronous active-low reset to 1 (idle)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync (
  input  logic baud_clk,
  input  logic reset_n,
  input  logic data_in,
  output logic data_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= data_in;
      r_sync <= r_meta;
    end
  end

  assign data_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx_sipo.sv
// ============================================================================
// uart_rx_sipo : oversampled 8-bit UART receiver (start, 8 data LSB-first,
//                parity, stop). Parity checking built only with
//                UART_RX_PARITY_CHECK_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic           baud_clk,
  input  logic           reset_n,
  uart_rx_sipo_if.master rx_if
);

  localparam int c_CNT_W = $clog2(OVERSAMPLE);
  localparam int c_IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [c_CNT_W-1:0] c_HALF_TICK = c_CNT_W'(OVERSAMPLE/2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL_TICK = c_CNT_W'(OVERSAMPLE - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(UART_DATA_BITS - 1);

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0) ||
      (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_param_check
    $error("uart_rx_sipo: illegal OVERSAMPLE or PARITY_ODD");
  end

  logic                      w_rx_s;
  uart_state_e               r_state, w_state_next;
  logic [c_CNT_W-1:0]        r_cnt, w_cnt_next;
  logic                      w_sample;
  logic [c_IDX_W-1:0]        r_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_rx_prev;
  logic [UART_DATA_BITS-1:0] r_data_out;
  logic                      r_valid;
  logic                      r_ferr;

  uart_rx_sync u_sync (
    .baud_clk  (baud_clk),
    .reset_n   (reset_n),
    .data_in   (rx_if.data_rx),
    .data_sync (w_rx_s)
  );

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Counter restarts at every sample point so each bit is centred.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_sample     = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (r_rx_prev && !w_rx_s) w_state_next = START;
      end
      START: begin
        if (r_cnt == c_HALF_TICK) begin
          w_cnt_next   = '0;
          w_state_next = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == c_FULL_TICK) begin
          w_cnt_next = '0;
          w_sample   = 1'b1;
          if (r_idx == c_LAST_IDX) w_state_next = PARITY;
        end
      end
      PARITY: begin
        if (r_cnt == c_FULL_TICK) begin
          w_cnt_next   = '0;
          w_sample     = 1'b1;
          w_state_next = STOP;
        end
      end
      STOP: begin
        if (r_cnt == c_FULL_TICK) begin
          w_cnt_next   = '0;
          w_sample     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_prev  <= 1'b1;
      r_idx      <= '0;
      r_shift    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_rx_prev <= w_rx_s;
      r_valid   <= 1'b0;
      if (r_state == START) begin
        r_idx <= '0;
      end
      if ((r_state == DATA) && w_sample) begin
        r_shift[r_idx] <= w_rx_s;
        r_idx          <= r_idx + 1'b1;
      end
      if ((r_state == STOP) && w_sample) begin
        r_data_out <= r_shift;
        r_ferr     <= !w_rx_s;
        r_valid    <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_CHECK_EN
  logic r_parity_bit;
  logic r_perr;

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity_bit <= 1'b0;
      r_perr       <= 1'b0;
    end else begin
      if ((r_state == PARITY) && w_sample) r_parity_bit <= w_rx_s;
      if ((r_state == STOP) && w_sample)
        r_perr <= (r_parity_bit != uart_parity(r_shift, 1'(PARITY_ODD)));
    end
  end

  assign rx_if.parity_error = r_perr;
`else
  assign rx_if.parity_error = 1'b0;
`endif

  assign rx_if.data_out      = r_data_out;
  assign rx_if.data_valid    = r_valid;
  assign rx_if.framing_error = r_ferr;
  assign rx_if.active_flag   = (r_state != IDLE);
  assign rx_if.done_flag     = (r_state == IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_sipo.sv
// ============================================================================
// tb_uart_rx_sipo : table-driven, directed and randomized frames for uart_rx_sipo
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_sipo;

  localparam int OS   = 16;
  localparam int PODD = 0;
`ifdef UART_RX_PARITY_CHECK_EN
  localparam bit c_PERR_EN = 1'b1;
`else
  localparam bit c_PERR_EN = 1'b0;
`endif
  // Edges from the start bit reaching data_rx to the strobe: 2 sync + 1 detect
  // + half a bit + ten bit periods.
  localparam int c_LAT = 3 + OS/2 + 10*OS;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rec_t;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  rec_t got_q[$];
  rec_t exp_q[$];

  uart_rx_sipo_if u_if ();

  uart_rx_sipo #(.OVERSAMPLE(OS), .PARITY_ODD(PODD)) u_dut (
    .baud_clk (clk),
    .reset_n  (rst_n),
    .rx_if    (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.data_valid)
      got_q.push_back('{cyc, u_if.data_out, u_if.parity_error, u_if.framing_error});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic model_perr(input logic [7:0] d, input logic p);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    ones += int'(p);
    return c_PERR_EN && ((ones % 2) != PODD);
  endfunction

  task automatic drive_bit(input logic b, input int n);
    u_if.data_rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, output int p0);
    p0 = cyc;
    drive_bit(1'b0, OS);
    for (int i = 0; i < 8; i++) drive_bit(d[i], OS);
    drive_bit(p, OS);
    drive_bit(s, OS);
  endtask

  task automatic expect_frame(input int p0, input logic [7:0] d, input logic p, input logic s);
    exp_q.push_back('{p0 + c_LAT, d, model_perr(d, p), !s});
  endtask

  task automatic drain_and_compare(input string tag);
    rec_t g, e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin
        n_err++;
        $display("FAIL %s strobe: got none expected one at cycle %0d", tag, e.cyc);
      end else begin
        g = got_q.pop_front();
        check({tag, " cycle"}, g.cyc, e.cyc);
        check({tag, " data"},  g.data, e.data);
        check({tag, " perr"},  g.perr, e.perr);
        check({tag, " ferr"},  g.ferr, e.ferr);
      end
    end
    check({tag, " extra strobes"}, got_q.size(), 0);
    got_q.delete();
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] d,
                                    input logic pe, input logic fe);
    @(negedge clk);
    check({tag, " data_out"},      u_if.data_out, d);
    check({tag, " parity_error"},  u_if.parity_error, pe);
    check({tag, " framing_error"}, u_if.framing_error, fe);
    check({tag, " active_flag"},   u_if.active_flag, 1'b0);
    check({tag, " done_flag"},     u_if.done_flag, 1'b1);
    check({tag, " data_valid"},    u_if.data_valid, 1'b0);
  endtask

  vec_t vecs[7];
  int   p0, p1;
  logic [7:0] last_d;
  logic       last_pe, last_fe;

  initial begin
    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 4,  8'hA5, 1'b0,      1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 4,  8'h01, c_PERR_EN, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 10, 8'h3C, 1'b0,      1'b1};
    vecs[3] = '{8'hC3, 1'b0, 1'b1, 4,  8'hC3, 1'b0,      1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 4,  8'hFF, 1'b0,      1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 4,  8'h00, c_PERR_EN, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 4,  8'h80, 1'b0,      1'b0};

    rst_n = 1'b0;
    u_if.data_rx = 1'b1;
    repeat (3) @(posedge clk);
    check_idle_outputs("reset", 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_bit(1'b1, 5);

    foreach (vecs[k]) begin
      send_frame(vecs[k].data, vecs[k].pbit, vecs[k].stop, p0);
      exp_q.push_back('{p0 + c_LAT, vecs[k].exp_data, vecs[k].exp_perr, vecs[k].exp_ferr});
      drive_bit(1'b1, vecs[k].gap);
      drain_and_compare($sformatf("vec%0d", k));
      check_idle_outputs($sformatf("vec%0d hold", k), vecs[k].exp_data,
                         vecs[k].exp_perr, vecs[k].exp_ferr);
    end

    // Low glitch shorter than half a bit: false start.
    p0 = cyc;
    drive_bit(1'b0, 3);
    u_if.data_rx = 1'b1;
    wait_cyc(p0 + 4);
    check("glitch active during start", u_if.active_flag, 1'b1);
    wait_cyc(p0 + 11);
    check("glitch active after start sample", u_if.active_flag, 1'b0);
    check("glitch done after start sample", u_if.done_flag, 1'b1);
    drive_bit(1'b1, 10);
    check("glitch strobes", got_q.size(), 0);
    check_idle_outputs("glitch hold", 8'h80, 1'b0, 1'b0);

    // Back-to-back frames, no idle gap.
    send_frame(8'h55, 1'b0, 1'b1, p0);
    send_frame(8'hAA, 1'b0, 1'b1, p1);
    check("b2b spacing", p1 - p0, 11*OS);
    expect_frame(p0, 8'h55, 1'b0, 1'b1);
    expect_frame(p1, 8'hAA, 1'b0, 1'b1);
    drive_bit(1'b1, 4);
    drain_and_compare("b2b");

    // Reset asserted just before the data bit 4 sample point.
    p0 = cyc;
    drive_bit(1'b0, OS);
    for (int i = 0; i < 4; i++) drive_bit(i[0], OS);
    u_if.data_rx = 1'b1;
    wait_cyc(p0 + 2 + OS/2 + 5*OS);
    #1;
    rst_n = 1'b0;
    check_idle_outputs("mid-frame reset", 8'h00, 1'b0, 1'b0);
    drive_bit(1'b1, 3*OS);
    rst_n = 1'b1;
    drive_bit(1'b1, 5);
    check("reset strobes", got_q.size(), 0);
    send_frame(8'h5A, 1'b0, 1'b1, p0);
    expect_frame(p0, 8'h5A, 1'b0, 1'b1);
    drive_bit(1'b1, 4);
    drain_and_compare("after reset");

    // Randomized frames with random gaps; a low stop bit needs a high gap.
    last_d = 8'h5A; last_pe = 1'b0; last_fe = 1'b0;
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      logic       p, s;
      int         gap;
      d   = 8'($urandom);
      p   = 1'($urandom);
      s   = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 20);
      if (!s && gap == 0) gap = 1;
      send_frame(d, p, s, p0);
      expect_frame(p0, d, p, s);
      if (gap > 0) drive_bit(1'b1, gap);
      last_d = d; last_pe = model_perr(d, p); last_fe = !s;
    end
    drive_bit(1'b1, 4);
    drain_and_compare("random");
    check_idle_outputs("random hold", last_d, last_pe, last_fe);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
